rx_fifo_rd_ctrl: RTL
====================

Name: rx_fifo_rd_ctrl

Overview:
Read-side controller for the PCS RX asynchronous elastic FIFO, in the rclk domain. It takes the two-flop-synchronised Gray write pointer and generates the binary read address and Gray read pointer. It also produces the empty, level and underflow indications. A prefill state machine holds off reads until the FIFO is centred, and re-centres after an underflow.

Parameters:
ADDRSIZE, 3, FIFO address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
START_LVL, 4, occupancy (words) required in FILL before reads start; legal range 1..2^ADDRSIZE.

Ports:
rclk  input  1  read-domain clock.
rrst_n  input  1  asynchronous active-low reset.
rq2_wptr  input  ADDRSIZE+1  synchronised Gray write pointer.
rd_en  input  1  consumer requests one word this cycle.
raddr  output  ADDRSIZE  binary read address to FIFO memory.
rptr  output  ADDRSIZE+1  Gray read pointer, to write-domain synchroniser.
rempty  output  1  FIFO empty, registered.
rvalid  output  1  memory read data valid, one cycle after the accepted read.
rlevel  output  ADDRSIZE+1  registered occupancy, 0..2^ADDRSIZE.
running  output  1  state == RUN.
underflow  output  1  one-cycle pulse on a read request while empty in RUN.

Behaviour:
- Reset (async, rrst_n=0), all registers cleared:
  - rbin=0, rptr=0, raddr=0.
  - rempty=1, rvalid=0, rlevel=0, running=0, underflow=0.
  - state=FILL.
- Write pointer conversion: wbin = Gray-to-binary(rq2_wptr), combinational.
- Pointer arithmetic:
  - rbin is binary, ADDRSIZE+1 bits, modulo 2^(ADDRSIZE+1) wrap.
  - raddr = rbin[ADDRSIZE-1:0].
  - rptr = registered Gray(rbin) = (rbin>>1)^rbin; it changes in the same cycle as rbin.
- rinc = (state==RUN) & rd_en & ~rempty.
  - rbin_next = rbin + rinc.
  - rgray_next = Gray(rbin_next).
- rempty <= (rgray_next == rq2_wptr). Empty therefore asserts in the same edge as the last read, with no bubble.
- rlevel <= (wbin - rbin_next) mod 2^(ADDRSIZE+1).
  - Values are exact 0..2^ADDRSIZE.
  - The value is pessimistic (low) by the synchroniser delay.
- rvalid <= rinc; memory read latency is 1 cycle, so data for raddr at edge N is valid at edge N+1.
- State machine, states FILL and RUN:
  - FILL: no reads; rd_en ignored; underflow never asserted. Go to RUN when the registered rlevel >= START_LVL.
  - RUN: reads as above. If rd_en=1 and rempty=1, pulse underflow for 1 cycle, do not increment rbin, and return to FILL next cycle.
  - Underflow is evaluated on registered rempty, so it has priority over any same-cycle write arrival. A write visible in rq2_wptr that cycle only clears rempty on the next edge.
- running = registered (state==RUN); asserts the cycle after the transition.
- Wrap-around: rbin passes 2^(ADDRSIZE+1)-1 -> 0 seamlessly. Empty and level must stay correct across the wrap.
- Full FIFO: rlevel = 2^ADDRSIZE (8 by default). This block does not throttle the writer; full is reported only through rlevel.
- Simultaneous read and write: level reflects both (rbin_next vs new wbin); the net change is 0.
- Reset mid-operation: pointers return to 0 immediately. The write side must also be reset. Any outstanding rvalid is dropped.

Test Plan:
- Reset then idle, rq2_wptr=0: rempty=1, rlevel=0, running=0, rptr=0000, rvalid never asserts.
- Prefill: Gray write pointer steps 0001,0011,0010,0110 with rd_en=1 throughout.
  - No reads occur until rlevel=4.
  - running=1 one cycle after the transition.
  - Reads then drain at 1/cycle: raddr 0,1,2,3; rvalid follows 1 cycle later.
  - rempty=1 on the edge after the 4th read.
- Underflow: in RUN with empty FIFO, rd_en=1 for 1 cycle.
  - underflow=1 for exactly 1 cycle; raddr unchanged; state returns to FILL.
  - Refilling to 4 re-enters RUN.
- Wrap: stream 40 words with the writer 2 ahead of the reader.
  - raddr cycles 0..7 five times.
  - rptr passes 1000 (binary 15->0 wrap) correctly.
  - rempty never asserts falsely; rlevel stays 2 throughout.
- Full: writer fills 8 words, rd_en=0: rlevel=8, rempty=0. Reading one word gives rlevel=7.
- Async reset asserted mid-stream, between clock edges: outputs return to reset values immediately, without waiting for rclk.

Source files
------------

// File: rtl/rx_fifo_rd_ctrl_if.sv
// Signal bundle between the RX elastic FIFO read controller and its consumer/memory.
// The controller uses the slave modport; the consumer side uses master.
interface rx_fifo_rd_ctrl_if #(
  parameter int ADDRSIZE = 3
);
  logic [ADDRSIZE:0]   rq2_wptr;
  logic                rd_en;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                rvalid;
  logic [ADDRSIZE:0]   rlevel;
  logic                running;
  logic                underflow;

  modport master (
    output rq2_wptr, rd_en,
    input  raddr, rptr, rempty, rvalid, rlevel, running, underflow
  );

  modport slave (
    input  rq2_wptr, rd_en,
    output raddr, rptr, rempty, rvalid, rlevel, running, underflow
  );
endinterface

// File: rtl/rx_fifo_rd_ctrl.sv
// Read-side controller of the PCS RX asynchronous elastic FIFO (rclk domain).
// Generates read address / Gray pointer, empty, level, underflow and a prefill FSM.
module rx_fifo_rd_ctrl #(
  parameter int ADDRSIZE  = 3,
  parameter int START_LVL = 4
) (
  input logic              rclk,
  input logic              rrst_n,
  rx_fifo_rd_ctrl_if.slave rd_if
);
  localparam int PW = ADDRSIZE + 1;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t        r_state;
  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_rlevel;
  logic          r_rempty;
  logic          r_rvalid;
  logic          r_running;
  logic          r_underflow;

  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic          w_rinc;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
    assign w_wbin[gi] = ^rd_if.rq2_wptr[PW-1:gi];
  end

  assign w_rinc       = (r_state == RUN) & rd_if.rd_en & ~r_rempty;
  assign w_rbin_next  = r_rbin + {{(PW-1){1'b0}}, w_rinc};
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state     <= FILL;
      r_rbin      <= '0;
      r_rptr      <= '0;
      r_rlevel    <= '0;
      r_rempty    <= 1'b1;
      r_rvalid    <= 1'b0;
      r_running   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rbin      <= w_rbin_next;
      r_rptr      <= w_rgray_next;
      r_rempty    <= (w_rgray_next == rd_if.rq2_wptr);
      r_rlevel    <= w_wbin - w_rbin_next;
      r_rvalid    <= w_rinc;
      r_running   <= (r_state == RUN);
      r_underflow <= 1'b0;
      if (r_state == FILL) begin
        if (r_rlevel >= PW'(START_LVL)) r_state <= RUN;
      end else begin
        // Registered empty wins over a write that lands this same cycle.
        if (rd_if.rd_en && r_rempty) begin
          r_underflow <= 1'b1;
          r_state     <= FILL;
        end
      end
    end
  end

  assign rd_if.raddr     = r_rbin[ADDRSIZE-1:0];
  assign rd_if.rptr      = r_rptr;
  assign rd_if.rempty    = r_rempty;
  assign rd_if.rvalid    = r_rvalid;
  assign rd_if.rlevel    = r_rlevel;
  assign rd_if.running   = r_running;
  assign rd_if.underflow = r_underflow;
endmodule
